// File: rtl/store_align_unit_pkg.sv
// Shared encodings for the store alignment unit: access sizes and FSM states.
package store_align_unit_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WRITE = 2'b01,
      DONE  = 2'b10,
      ERR   = 2'b11
   } state_e;

   localparam int unsigned NUM_LANES = 4;

endpackage

// File: rtl/store_lane_steer.sv
// Combinational lane steering: replicates store data across byte lanes, builds
// the byte strobe and flags misaligned or reserved-size accesses.
module store_lane_steer
   import store_align_unit_pkg::*;
(
   input  size_e                  size,
   input  logic [1:0]             addr_lo,
   input  logic [31:0]            data,
   output logic [31:0]            wdata,
   output logic [NUM_LANES-1:0]   strb,
   output logic                   misaligned
);

   always_comb begin
      wdata      = '0;
      strb       = '0;
      misaligned = 1'b0;
      case (size)
         SZ_BYTE: begin
            wdata = {4{data[7:0]}};
            strb  = 4'b0001 << addr_lo;
         end
         SZ_HALF: begin
            wdata      = {2{data[15:0]}};
            strb       = addr_lo[1] ? 4'b1100 : 4'b0011;
            misaligned = addr_lo[0];
         end
         SZ_WORD: begin
            wdata      = data;
            strb       = 4'b1111;
            misaligned = (addr_lo != 2'b00);
         end
         // Reserved size is rejected the same way as a misaligned access.
         default: misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: accepts one store at a time, steers it onto a word-wide
// memory port and reports completion or a misalignment error.
module store_align_unit
   import store_align_unit_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    st_valid,
   output logic                    st_ready,
   input  logic [1:0]              st_size,
   input  logic [ADDR_WIDTH-1:0]   st_addr,
   input  logic [DATA_WIDTH-1:0]   st_data,
   output logic                    st_done,
   output logic                    st_err,
   output logic                    mem_write,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [NUM_LANES-1:0]    mem_strb,
   input  logic                    mem_ready
);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [NUM_LANES-1:0]    strb_q;

   logic [31:0]             steer_wdata;
   logic [NUM_LANES-1:0]    steer_strb;
   logic                    steer_misaligned;
   logic                    accept;

   // Steering is done on the incoming request so the accept edge already knows
   // whether the store is legal; the steered result is what gets latched.
   store_lane_steer u_steer (
      .size       (size_e'(st_size)),
      .addr_lo    (st_addr[1:0]),
      .data       (st_data),
      .wdata      (steer_wdata),
      .strb       (steer_strb),
      .misaligned (steer_misaligned)
   );

   assign accept = st_valid && st_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= {st_addr[ADDR_WIDTH-1:2], 2'b00};
            wdata_q <= steer_wdata;
            strb_q  <= steer_strb;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = steer_misaligned ? ERR : WRITE;
         WRITE:   if (mem_ready) state_d = DONE;
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Memory-side outputs are zero whenever no write is in flight.
   always_comb begin
      st_ready  = (state_q == IDLE);
      st_done   = (state_q == DONE);
      st_err    = (state_q == ERR);
      mem_write = (state_q == WRITE);
      mem_addr  = mem_write ? addr_q  : '0;
      mem_wdata = mem_write ? wdata_q : '0;
      mem_strb  = mem_write ? strb_q  : '0;
   end

endmodule

// File: tb/tb_store_align_unit.sv
// Self-checking bench for store_align_unit using an expected-write scoreboard.
module tb_store_align_unit;

   localparam int AW = 32;

   logic            clk = 1'b0;
   logic            resetn;
   logic            st_valid;
   logic            st_ready;
   logic [1:0]      st_size;
   logic [AW-1:0]   st_addr;
   logic [31:0]     st_data;
   logic            st_done;
   logic            st_err;
   logic            mem_write;
   logic [AW-1:0]   mem_addr;
   logic [31:0]     mem_wdata;
   logic [3:0]      mem_strb;
   logic            mem_ready;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } wr_t;

   wr_t exp_q[$];
   int  total = 0;
   int  bad = 0;
   int  cyc = 0;
   int  n_pushed = 0;
   int  n_writes = 0;

   store_align_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_size   (st_size),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .st_done   (st_done),
      .st_err    (st_err),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_strb  (mem_strb),
      .mem_ready (mem_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic exp_err(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
   endfunction

   function automatic wr_t exp_wr(input logic [1:0] sz, input logic [31:0] a,
                                  input logic [31:0] d);
      wr_t w;
      w.addr = {a[31:2], 2'b00};
      case (sz)
         2'b00:   begin w.wdata = {4{d[7:0]}};  w.strb = 4'b0001 << a[1:0]; end
         2'b01:   begin w.wdata = {2{d[15:0]}}; w.strb = a[1] ? 4'b1100 : 4'b0011; end
         default: begin w.wdata = d;            w.strb = 4'b1111; end
      endcase
      return w;
   endfunction

   // Scoreboard side: every completed memory handshake must match the oldest prediction.
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         check("done_err_excl", {31'b0, st_done & st_err}, 32'd0);
         if (mem_write && mem_ready) begin
            n_writes++;
            check("write_expected", {31'b0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
               wr_t e;
               e = exp_q.pop_front();
               check("sb_addr", mem_addr, e.addr);
               check("sb_wdata", mem_wdata, e.wdata);
               check("sb_strb", {28'b0, mem_strb}, {28'b0, e.strb});
            end
         end
      end
   end

   task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                           input int nwait);
      logic err;
      wr_t  e;
      err = exp_err(sz, a);
      e   = exp_wr(sz, a, d);
      check("ready_before", {31'b0, st_ready}, 32'd1);
      st_valid  = 1'b1;
      st_size   = sz;
      st_addr   = a;
      st_data   = d;
      mem_ready = 1'b0;
      @(posedge clk); #1;
      // Scramble inputs after accept: the latched request must be unaffected.
      st_valid = 1'b0;
      st_size  = 2'($urandom);
      st_addr  = $urandom;
      st_data  = $urandom;
      if (err) begin
         check("err_pulse", {31'b0, st_err}, 32'd1);
         check("err_nowrite", {31'b0, mem_write}, 32'd0);
         check("err_notdone", {31'b0, st_done}, 32'd0);
         @(posedge clk); #1;
         check("err_one_cycle", {31'b0, st_err}, 32'd0);
         check("err_nowrite2", {31'b0, mem_write}, 32'd0);
         check("err_ready", {31'b0, st_ready}, 32'd1);
      end else begin
         exp_q.push_back(e);
         n_pushed++;
         for (int i = 0; i <= nwait; i++) begin
            check("wr_valid", {31'b0, mem_write}, 32'd1);
            check("wr_addr_hold", mem_addr, e.addr);
            check("wr_wdata_hold", mem_wdata, e.wdata);
            check("wr_strb_hold", {28'b0, mem_strb}, {28'b0, e.strb});
            check("wr_not_ready", {31'b0, st_ready}, 32'd0);
            check("wr_not_done", {31'b0, st_done}, 32'd0);
            if (i == nwait) mem_ready = 1'b1;
            @(posedge clk); #1;
         end
         check("done_pulse", {31'b0, st_done}, 32'd1);
         check("done_nowrite", {31'b0, mem_write}, 32'd0);
         mem_ready = 1'b0;
         @(posedge clk); #1;
         check("done_one_cycle", {31'b0, st_done}, 32'd0);
         check("idle_ready", {31'b0, st_ready}, 32'd1);
      end
   endtask

   initial begin
      int acc[4];
      resetn    = 1'b1;
      st_valid  = 1'b0;
      st_size   = 2'b00;
      st_addr   = '0;
      st_data   = '0;
      mem_ready = 1'b0;
      #1 resetn = 1'b0;
      #1;
      check("rst_ready", {31'b0, st_ready}, 32'd1);
      check("rst_write", {31'b0, mem_write}, 32'd0);
      check("rst_done", {31'b0, st_done}, 32'd0);
      check("rst_err", {31'b0, st_err}, 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_strb", {28'b0, mem_strb}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      resetn = 1'b1;

      // Directed cases, starting with an accept on the first edge after reset.
      do_store(2'b00, 32'h0000_1003, 32'hAABB_CC5A, 0);
      do_store(2'b01, 32'h0000_2002, 32'h1234_BEEF, 3);
      do_store(2'b10, 32'h0000_3001, 32'h1111_2222, 0);
      do_store(2'b01, 32'h0000_3001, 32'h3333_4444, 0);
      do_store(2'b11, 32'h0000_3000, 32'h5555_6666, 0);
      do_store(2'b10, 32'h0000_5000, 32'hCAFE_F00D, 1);
      do_store(2'b01, 32'h0000_6000, 32'hFFFF_0180, 0);
      do_store(2'b00, 32'h0000_7001, 32'h0000_00C3, 2);

      // mem_ready activity while idle must be ignored.
      for (int i = 0; i < 6; i++) begin
         mem_ready = i[0];
         @(posedge clk); #1;
         check("idle_mr_ready", {31'b0, st_ready}, 32'd1);
         check("idle_mr_done", {31'b0, st_done}, 32'd0);
         check("idle_mr_write", {31'b0, mem_write}, 32'd0);
      end
      mem_ready = 1'b0;

      // Back-to-back byte stores with st_valid held high and memory always ready.
      mem_ready = 1'b1;
      st_valid  = 1'b1;
      st_size   = 2'b00;
      st_data   = 32'hA5C3_0F96;
      for (int k = 0; k < 4; k++) begin
         wr_t e;
         st_addr = 32'h10 + k;
         e = exp_wr(2'b00, st_addr, st_data);
         exp_q.push_back(e);
         n_pushed++;
         @(posedge clk); #1;
         acc[k] = cyc;
         check("b2b_write", {31'b0, mem_write}, 32'd1);
         check("b2b_strb", {28'b0, mem_strb}, {28'b0, 4'b0001 << k});
         @(posedge clk); #1;
         check("b2b_done", {31'b0, st_done}, 32'd1);
         check("b2b_no_accept_in_done", {31'b0, st_ready}, 32'd0);
         if (k == 3) st_valid = 1'b0;
         @(posedge clk); #1;
         check("b2b_ready", {31'b0, st_ready}, 32'd1);
         if (k > 0) check("b2b_spacing", acc[k] - acc[k-1], 32'd3);
      end
      mem_ready = 1'b0;

      // Reset in the middle of a stalled write aborts it.
      st_valid = 1'b1;
      st_size  = 2'b10;
      st_addr  = 32'h0000_4000;
      st_data  = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      st_valid = 1'b0;
      check("abort_write_up", {31'b0, mem_write}, 32'd1);
      @(posedge clk); #1;
      resetn = 1'b0;
      #1;
      check("abort_write_drop", {31'b0, mem_write}, 32'd0);
      check("abort_ready", {31'b0, st_ready}, 32'd1);
      check("abort_addr", mem_addr, 32'd0);
      check("abort_wdata", mem_wdata, 32'd0);
      check("abort_strb", {28'b0, mem_strb}, 32'd0);
      check("abort_done", {31'b0, st_done}, 32'd0);
      #1 resetn = 1'b1;
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("abort_no_done", {31'b0, st_done}, 32'd0);
         check("abort_no_write", {31'b0, mem_write}, 32'd0);
      end
      mem_ready = 1'b0;

      // Randomised mix of sizes, alignments and memory stalls.
      for (int i = 0; i < 12; i++) begin
         do_store(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 2));
      end

      repeat (2) @(posedge clk);
      #1;
      check("sb_queue_empty", exp_q.size(), 32'd0);
      check("sb_write_count", n_writes, n_pushed);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got=timeout want=finish");
      $fatal(1);
   end

endmodule

// File: doc/store_align_unit.md
STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: byte-address width.
REQ-002 Parameter DATA_WIDTH, default 32: store data width; fixed at 32.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 st_valid  input  1  core presents a store request.
REQ-006 st_ready  output  1  unit can accept a request.
REQ-007 st_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 st_addr  input  ADDR_WIDTH  byte address of store.
REQ-009 st_data  input  32  register value, value in low bits.
REQ-010 st_done  output  1  one-cycle pulse: store committed to memory.
REQ-011 st_err  output  1  one-cycle pulse: misaligned or reserved-size store, no write.
REQ-012 mem_write  output  1  memory write request.
REQ-013 mem_addr  output  ADDR_WIDTH  word-aligned address.
REQ-014 mem_wdata  output  32  lane-replicated write data.
REQ-015 mem_strb  output  4  byte-lane write enables.
REQ-016 mem_ready  input  1  memory accepts the write this cycle.

Function
REQ-017 FSM states IDLE, WRITE, DONE, ERR; st_ready SHALL be 1 only in IDLE.
REQ-018 Request accepted on rising edge with st_valid && st_ready; st_size, st_addr, st_data latched into registers; inputs ignored outside IDLE.
REQ-019 Accept with misalignment (half: addr[0]=1; word: addr[1:0]!=00) or st_size=11 -> ERR; else -> WRITE.
REQ-020 ERR: st_err=1 for exactly one cycle, mem_write=0 throughout, then IDLE.
REQ-021 WRITE: mem_write=1; mem_addr, mem_wdata, mem_strb driven from latched registers and stable until mem_ready.
REQ-022 WRITE with mem_ready=1 -> DONE; mem_ready=0 -> stay in WRITE (unbounded wait).
REQ-023 DONE: st_done=1 for one cycle, mem_write=0, then IDLE.
REQ-024 Latency: accept at edge N, mem_write high cycle N+1; zero-wait memory gives st_done cycle N+2; next accept earliest edge N+3.
REQ-025 mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
REQ-026 Byte: mem_wdata = data[7:0] replicated 4x; mem_strb = 0001 shifted left by addr[1:0].
REQ-027 Half: mem_wdata = data[15:0] replicated 2x; mem_strb = 1100 if addr[1] else 0011.
REQ-028 Word: mem_wdata = data; mem_strb = 1111.
REQ-029 Upper bits of st_data beyond the selected size SHALL never affect enabled lanes (inverse of load sign/zero extension: truncation, no range check).
REQ-030 mem_ready outside WRITE SHALL be ignored.
REQ-031 st_done and st_err SHALL never be high in the same cycle.

Reset
REQ-032 resetn low SHALL immediately force IDLE, st_ready=1, mem_write=0, st_done=0, st_err=0, mem_addr/mem_wdata/mem_strb=0.
REQ-033 Reset during WRITE aborts the store: no st_done, latched request discarded.
REQ-034 First accept possible on first rising edge after resetn deasserts.

Structure
REQ-035 Shared package holds size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD) and state encodings.
REQ-036 Lane steering (size, addr[1:0], data -> wdata, strb, misaligned) SHALL be one combinational sub-module store_lane_steer; FSM and registers in store_align_unit.

Verification
REQ-037 sb, addr 0x1003, data 0xAABBCC5A, mem_ready=1 -> mem_addr 0x1000, wdata 0x5A5A5A5A, strb 1000, st_done at N+2.
REQ-038 sh, addr 0x2002, data 0x1234BEEF, mem_ready low 3 cycles -> outputs held stable 4 cycles, wdata 0xBEEFBEEF, strb 1100, st_done one cycle after mem_ready.
REQ-039 sw, addr 0x3001 -> st_err one cycle at N+1, mem_write never high; sh addr 0x3001 and st_size=11 likewise.
REQ-040 sw, addr 0x4000, data 0xDEADBEEF, resetn pulsed low during WRITE -> mem_write drops immediately, no st_done, st_ready=1.
REQ-041 Back-to-back st_valid held high with sb 0x10/0x11/0x12/0x13 -> four writes, strb 0001,0010,0100,1000, one accept every 3 cycles.
REQ-042 mem_ready toggled while IDLE/DONE -> no state change, no spurious st_done.
